// File: rtl/dma_controller.sv
// dma_controller: moves device bursts into D-memory. A command (start word
// address, length in words) is split into ceil(length/BURST_WORDS) full bursts.
// Each burst is one device fetch cycle followed by MEM_LATENCY write cycles.
// The memory bus is requested with BR and used only while BG is held by the
// bus owner.
//
// Handshakes:
// - cmd_valid is a single-cycle strobe that is accepted only in IDLE.
// - BR is held high from acceptance until the last burst finishes.
// - BG is sampled only in REQ, and at the end of each burst. A burst that has
//   started always runs to completion.
// - dev_rd is high for exactly one cycle. dev_data is captured on the clock
//   edge that ends that cycle.
module dma_controller #(
  parameter int WORD_SIZE   = 16,
  parameter int FETCH_SIZE  = 64,
  parameter int BURST_WORDS = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [WORD_SIZE-1:0]  cmd_addr,
  input  logic [WORD_SIZE-1:0]  cmd_length,
  input  logic                  BG,
  input  logic [FETCH_SIZE-1:0] dev_data,
  output logic                  BR,
  output logic                  dev_rd,
  output logic                  d_writeM,
  output logic [WORD_SIZE-1:0]  d_addressM,
  output logic [FETCH_SIZE-1:0] d_dataM,
  output logic                  dma_end,
  output logic                  busy
);

  localparam int WCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WCW-1:0]       LP_WLAST = WCW'(MEM_LATENCY - 1);
  localparam logic [WORD_SIZE-1:0] LP_BW    = WORD_SIZE'(BURST_WORDS);
  localparam logic [WORD_SIZE-1:0] LP_ONE   = WORD_SIZE'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_FETCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [WORD_SIZE-1:0]  r_addr;
  logic [WORD_SIZE-1:0]  r_remain;
  logic [FETCH_SIZE-1:0] r_buf;
  logic [WCW-1:0]        r_wcnt;
  logic                  r_br;
  logic                  r_dev_rd;
  logic                  r_write;
  logic                  r_drive;
  logic                  r_dma_end;
  logic [WORD_SIZE-1:0]  w_bursts;

  // Burst count for an incoming command; a trailing partial burst counts as a full one
  always_comb begin
    w_bursts = cmd_length / LP_BW;
    if ((cmd_length % LP_BW) != '0) begin
      w_bursts = w_bursts + LP_ONE;
    end
  end

  // Transfer FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_remain  <= '0;
      r_buf     <= '0;
      r_wcnt    <= '0;
      r_br      <= 1'b0;
      r_dev_rd  <= 1'b0;
      r_write   <= 1'b0;
      r_drive   <= 1'b0;
      r_dma_end <= 1'b0;
    end else begin
      r_dev_rd  <= 1'b0;
      r_write   <= 1'b0;
      r_dma_end <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr   <= cmd_addr;
            r_remain <= w_bursts;
            if (cmd_length == '0) begin
              r_state   <= S_DONE;
              r_dma_end <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_br    <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (BG) begin
            r_state  <= S_FETCH;
            r_dev_rd <= 1'b1;
          end
        end
        S_FETCH: begin
          r_buf   <= dev_data;
          r_state <= S_WRITE;
          r_write <= 1'b1;
          r_drive <= 1'b1;
          r_wcnt  <= '0;
        end
        S_WRITE: begin
          if (r_wcnt == LP_WLAST) begin
            // Burst finished: advance to the next burst (the address wraps naturally)
            r_addr   <= r_addr + LP_BW;
            r_remain <= r_remain - LP_ONE;
            r_drive  <= 1'b0;
            if (r_remain == LP_ONE) begin
              r_state   <= S_DONE;
              r_br      <= 1'b0;
              r_dma_end <= 1'b1;
            end else if (BG) begin
              r_state  <= S_FETCH;
              r_dev_rd <= 1'b1;
            end else begin
              r_state <= S_REQ;
            end
          end else begin
            r_wcnt <= r_wcnt + WCW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_br    <= 1'b0;
          r_drive <= 1'b0;
        end
      endcase
    end
  end

  assign BR         = r_br;
  assign dev_rd     = r_dev_rd;
  assign d_writeM   = r_write;
  assign dma_end    = r_dma_end;
  assign busy       = (r_state != S_IDLE);
  assign d_addressM = r_drive ? r_addr : {WORD_SIZE{1'bz}};
  assign d_dataM    = r_drive ? r_buf  : {FETCH_SIZE{1'bz}};

endmodule

// File: tb/tb_dma_controller.sv
// Bench for dma_controller.
// - The expected addresses are derived from the command: addr + k*BURST_WORDS
//   for k = 0 .. ceil(len/BURST_WORDS)-1.
// - The expected data is whatever the bench presented on dev_data during each
//   dev_rd cycle.
// - Cycle tables are checked against the directed timing scenarios.
module tb_dma_controller;
  localparam int WS = 16;
  localparam int FS = 64;
  localparam int BW = 4;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [WS-1:0] cmd_addr;
  logic [WS-1:0] cmd_length;
  logic          BG;
  logic [FS-1:0] dev_data;
  logic          BR;
  logic          dev_rd;
  logic          d_writeM;
  wire  [WS-1:0] d_addressM;
  wire  [FS-1:0] d_dataM;
  logic          dma_end;
  logic          busy;

  dma_controller #(
    .WORD_SIZE(WS), .FETCH_SIZE(FS), .BURST_WORDS(BW), .MEM_LATENCY(ML)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_length(cmd_length), .BG(BG), .dev_data(dev_data), .BR(BR),
    .dev_rd(dev_rd), .d_writeM(d_writeM), .d_addressM(d_addressM),
    .d_dataM(d_dataM), .dma_end(dma_end), .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int end_cnt = 0;
  bit bg_rand = 1'b0;
  bit noise   = 1'b0;

  // Scoreboard state
  logic [WS-1:0] exp_q[$];
  logic [FS-1:0] data_q[$];
  int            wr_left = 0;
  logic [WS-1:0] hold_addr;
  logic [FS-1:0] hold_data;
  logic          prev_dev_rd = 1'b0;

  task automatic chk(input string tag, input logic [FS-1:0] obs, input logic [FS-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_float(input string tag);
    n_tests++;
    assert (((d_addressM === {WS{1'bz}}) || (d_addressM === '0)) &&
            ((d_dataM === {FS{1'bz}}) || (d_dataM === '0))) else begin
      n_fail++;
      $error("FAIL %s: observed addr %0h data %0h expected z", tag, d_addressM, d_dataM);
    end
  endtask

  // Monitor: burst contents, bus release, busy/BR consistency
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      data_q.delete();
      wr_left     = 0;
      prev_dev_rd = 1'b0;
    end else begin
      chk("busy_vs_br", FS'(busy), FS'(BR | dma_end));
      if (dma_end) begin
        end_cnt++;
        chk("br_in_done", FS'(BR), '0);
      end
      chk("write_after_fetch", FS'(d_writeM), FS'(prev_dev_rd));
      if (dev_rd) data_q.push_back(dev_data);
      if (d_writeM) begin
        n_tests++;
        assert (exp_q.size() > 0 && data_q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_write: observed addr %0h expected no write", d_addressM);
        end
        if (exp_q.size() > 0 && data_q.size() > 0) begin
          hold_addr = exp_q.pop_front();
          hold_data = data_q.pop_front();
          chk("write_addr", FS'(d_addressM), FS'(hold_addr));
          chk("write_data", d_dataM, hold_data);
        end
        wr_left = ML - 1;
      end else if (wr_left > 0) begin
        chk("burst_hold_addr", FS'(d_addressM), FS'(hold_addr));
        chk("burst_hold_data", d_dataM, hold_data);
        wr_left--;
      end else begin
        chk_float("bus_idle");
      end
      prev_dev_rd = dev_rd;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    dev_data = {$urandom, $urandom};
    if (bg_rand) BG = 1'($urandom_range(0, 1));
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [WS-1:0] addr, input int len);
    int nb;
    nb = (len + BW - 1) / BW;
    for (int k = 0; k < nb; k++) exp_q.push_back(WS'(int'(addr) + k * BW));
  endtask

  task automatic issue(input logic [WS-1:0] addr, input int len);
    step();
    cmd_valid  = 1'b1;
    cmd_addr   = addr;
    cmd_length = WS'(len);
    push_expect(addr, len);
  endtask

  task automatic wait_end(input int start, input string tag);
    for (int k = 0; k < 600 && end_cnt == start; k++) begin
      step();
      if (noise) begin
        cmd_valid = ($urandom_range(0, 3) == 0);
        cmd_addr  = WS'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      sample();
    end
    cmd_valid = 1'b0;
    chk({tag, "_end_seen"}, FS'(end_cnt - start), FS'(1));
    chk({tag, "_all_bursts"}, FS'(exp_q.size()), '0);
  endtask

  task automatic run_cmd(input logic [WS-1:0] addr, input int len, input string tag);
    int s;
    s = end_cnt;
    issue(addr, len);
    wait_end(s, tag);
  endtask

  initial begin
    int s;
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_length = '0;
    BG = 1'b0; dev_data = '0;
    repeat (3) @(posedge clk);
    sample();
    chk("rst_br", FS'(BR), '0);
    chk("rst_dev_rd", FS'(dev_rd), '0);
    chk("rst_writem", FS'(d_writeM), '0);
    chk("rst_dma_end", FS'(dma_end), '0);
    chk("rst_busy", FS'(busy), '0);
    chk_float("rst_bus");
    step();
    reset = 1'b0;

    // Full 12-word transfer with BG tied high: fixed cycle table
    BG = 1'b1;
    issue(16'h01F4, 12);
    for (int k = 1; k <= 17; k++) begin
      step();
      cmd_valid = 1'b0;
      sample();
      chk($sformatf("t12_br_%0d", k), FS'(BR), FS'(k <= 16));
      chk($sformatf("t12_dev_rd_%0d", k), FS'(dev_rd), FS'(k == 2 || k == 7 || k == 12));
      chk($sformatf("t12_writem_%0d", k), FS'(d_writeM), FS'(k == 3 || k == 8 || k == 13));
      chk($sformatf("t12_end_%0d", k), FS'(dma_end), FS'(k == 17));
    end
    chk("t12_all_bursts", FS'(exp_q.size()), '0);

    // Grant withheld for 10 cycles after BR rises
    BG = 1'b0;
    s = end_cnt;
    issue(16'h0100, 4);
    step();
    cmd_valid = 1'b0;
    sample();
    chk("bg0_br_rise", FS'(BR), FS'(1));
    for (int j = 0; j < 10; j++) begin
      step();
      sample();
      chk("bg0_no_fetch", FS'(dev_rd), '0);
      chk("bg0_no_write", FS'(d_writeM), '0);
      chk("bg0_br_hold", FS'(BR), FS'(1));
    end
    step();
    BG = 1'b1;
    sample();
    chk("bg_fetch_not_early", FS'(dev_rd), '0);
    step();
    sample();
    chk("bg_fetch_next", FS'(dev_rd), FS'(1));
    wait_end(s, "bg0");

    // Grant dropped in the 2nd write cycle of burst 1 (cycles T+4..T+9)
    BG = 1'b1;
    issue(16'h0200, 8);
    for (int k = 1; k <= 16; k++) begin
      step();
      cmd_valid = 1'b0;
      BG = !(k >= 4 && k <= 9);
      sample();
      chk($sformatf("drop_br_%0d", k), FS'(BR), FS'(k <= 15));
      chk($sformatf("drop_dev_rd_%0d", k), FS'(dev_rd), FS'(k == 2 || k == 11));
      chk($sformatf("drop_writem_%0d", k), FS'(d_writeM), FS'(k == 3 || k == 12));
      chk($sformatf("drop_end_%0d", k), FS'(dma_end), FS'(k == 16));
    end
    chk("drop_all_bursts", FS'(exp_q.size()), '0);

    // Zero length: the pulse lands in the cycle after acceptance, BR stays low
    BG = 1'b0;
    issue(16'h1234, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      cmd_valid = 1'b0;
      sample();
      chk($sformatf("len0_br_%0d", k), FS'(BR), '0);
      chk($sformatf("len0_end_%0d", k), FS'(dma_end), FS'(k == 1));
    end

    // Partial final burst and address wrap
    BG = 1'b1;
    run_cmd(16'h0040, 5, "len5");
    run_cmd(16'hFFFC, 8, "wrap");

    // Reset during the 2nd write cycle
    issue(16'h0300, 8);
    for (int k = 1; k <= 3; k++) begin
      step();
      cmd_valid = 1'b0;
      sample();
    end
    step();
    reset = 1'b1;
    sample();
    s = end_cnt;
    step();
    reset = 1'b0;
    sample();
    chk("rst_mid_br", FS'(BR), '0);
    chk("rst_mid_busy", FS'(busy), '0);
    chk("rst_mid_writem", FS'(d_writeM), '0);
    chk("rst_mid_dev_rd", FS'(dev_rd), '0);
    chk("rst_mid_end", FS'(dma_end), '0);
    chk_float("rst_mid_bus");
    repeat (6) begin
      step();
      sample();
    end
    chk("rst_mid_no_end", FS'(end_cnt - s), '0);
    run_cmd(16'h0400, 7, "after_rst");

    // Random commands, random grant, stray cmd_valid while busy
    bg_rand = 1'b1;
    noise   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_cmd(WS'($urandom), $urandom_range(1, 13), $sformatf("rand%0d", i));
    end
    bg_rand = 1'b0;
    noise   = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
